// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    localparam int XLEN     = 64;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    // Requester identifiers; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // One queued writeback: destination register plus result.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register index into a per-register mask.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [AW-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small writeback FIFO with an occupied-destination mask for hazard tracking.
// Latency: an entry pushed at posedge N is visible at the head after N.
// Backpressure: full_o is pure FIFO state; a push while full is dropped, pop never bypasses.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  wb_entry_t           push_dat_i,
    input  logic                pop_i,
    output logic                full_o,
    output logic                empty_o,
    output wb_entry_t           head_o,
    output logic [NUM_REGS-1:0] rd_mask_o
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    wb_entry_t     mem_q [DEPTH];
    logic          do_push, do_pop;
    logic [PW-1:0] slot_off;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count state; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots inside the occupied window are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        rd_mask_o = '0;
        slot_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if ({1'b0, slot_off} < count_q) rd_mask_o = rd_mask_o | rd_onehot(mem_q[i].rd);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between ALU and load writebacks.
// Latency: accept at posedge N, write enable high N+1..N+2 when uncontended.
// Backpressure: per-requester ready = FIFO not full, independent of valid; x0 writes are swallowed.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    // Widths follow the package entry type; these exist so the port list reads naturally.
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int AW    = regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            regWrite,
    output logic [AW-1:0]   writeRegister,
    output logic [XLEN-1:0] writeData,
    output logic [31:0]     pending
);

    wb_entry_t           alu_push_dat, mem_push_dat;
    wb_entry_t           alu_head, mem_head;
    logic                alu_full, alu_empty, mem_full, mem_empty;
    logic                alu_push, mem_push, alu_pop, mem_pop;
    logic [NUM_REGS-1:0] alu_mask, mem_mask;

    // Most recently granted requester; reset to MEM so the first tie goes to ALU.
    req_e                last_gnt_q, last_gnt_d;
    logic                reg_write_q, reg_write_d;
    logic [AW-1:0]       wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;

    assign alu_ready    = !alu_full;
    assign mem_ready    = !mem_full;
    // x0 completes the handshake but never enters a FIFO.
    assign alu_push     = alu_valid && !alu_full && (alu_rd != '0);
    assign mem_push     = mem_valid && !mem_full && (mem_rd != '0);
    assign alu_push_dat = '{rd: alu_rd, data: alu_data};
    assign mem_push_dat = '{rd: mem_rd, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (alu_push),
        .push_dat_i (alu_push_dat),
        .pop_i      (alu_pop),
        .full_o     (alu_full),
        .empty_o    (alu_empty),
        .head_o     (alu_head),
        .rd_mask_o  (alu_mask)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (mem_push),
        .push_dat_i (mem_push_dat),
        .pop_i      (mem_pop),
        .full_o     (mem_full),
        .empty_o    (mem_empty),
        .head_o     (mem_head),
        .rd_mask_o  (mem_mask)
    );

    // Grant selection and output-stage next state; address/data hold when idle.
    always_comb begin
        alu_pop     = 1'b0;
        mem_pop     = 1'b0;
        last_gnt_d  = last_gnt_q;
        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        if (!alu_empty && (mem_empty || last_gnt_q == REQ_MEM)) begin
            alu_pop     = 1'b1;
            last_gnt_d  = REQ_ALU;
            reg_write_d = 1'b1;
            wr_reg_d    = alu_head.rd;
            wr_data_d   = alu_head.data;
        end else if (!mem_empty) begin
            mem_pop     = 1'b1;
            last_gnt_d  = REQ_MEM;
            reg_write_d = 1'b1;
            wr_reg_d    = mem_head.rd;
            wr_data_d   = mem_head.data;
        end
    end

    // Registered write port and round-robin pointer; reset kills any write in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= REQ_MEM;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign regWrite      = reg_write_q;
    assign writeRegister = wr_reg_q;
    assign writeData     = wr_data_q;
    assign pending       = alu_mask | mem_mask | (reg_write_q ? rd_onehot(wr_reg_q) : '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a queue model.
// Latency: checks one time unit after every rising edge.
// Backpressure: model ready is derived from model queue occupancy.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [63:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, regWrite;
    logic [4:0]  writeRegister;
    logic [63:0] writeData;
    logic [31:0] pending;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per requester, plus the write-port contents.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        qa[$];
    ent_t        qm[$];
    bit          last_was_alu;
    bit          m_we;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          wlog[$];
    int          exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = '0;
        foreach (qa[i]) p[qa[i].rd] = 1'b1;
        foreach (qm[i]) p[qm[i].rd] = 1'b1;
        if (m_we) p[m_wr] = 1'b1;
        return p;
    endfunction

    task automatic reset_model();
        qa.delete();
        qm.delete();
        last_was_alu = 1'b0;
        m_we = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endtask

    task automatic check_all(input string lbl);
        chk({lbl, ".alu_ready"}, alu_ready, (qa.size() < DEPTH));
        chk({lbl, ".mem_ready"}, mem_ready, (qm.size() < DEPTH));
        chk({lbl, ".regWrite"}, regWrite, m_we);
        chk({lbl, ".writeRegister"}, writeRegister, m_wr);
        chk({lbl, ".writeData"}, writeData, m_wd);
        chk({lbl, ".pending"}, pending, exp_pending());
    endtask

    // One clock: drive inputs, advance the model across the edge, then check.
    task automatic step(input string lbl,
                        input bit av, input logic [4:0] ard, input logic [63:0] adat,
                        input bit mv, input logic [4:0] mrd, input logic [63:0] mdat);
        bit a_take, m_take;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        a_take = av && (qa.size() < DEPTH);
        m_take = mv && (qm.size() < DEPTH);
        @(posedge clk);
        if (qa.size() > 0 && (qm.size() == 0 || !last_was_alu)) begin
            m_we = 1'b1; m_wr = qa[0].rd; m_wd = qa[0].data;
            void'(qa.pop_front());
            last_was_alu = 1'b1;
        end else if (qm.size() > 0) begin
            m_we = 1'b1; m_wr = qm[0].rd; m_wd = qm[0].data;
            void'(qm.pop_front());
            last_was_alu = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (a_take && ard != 0) begin qa.push_back('{ard, adat}); n_acc++; end
        if (m_take && mrd != 0) begin qm.push_back('{mrd, mdat}); n_acc++; end
        #1;
        check_all(lbl);
        if (regWrite === 1'b1) wlog.push_back(int'(writeRegister));
    endtask

    task automatic idle(input string lbl, input int n);
        for (int i = 0; i < n; i++) step(lbl, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset(input string lbl);
        #2 rst = 1'b1;
        #1;
        reset_model();
        check_all(lbl);
        #3 rst = 1'b0;
    endtask

    task automatic check_log(input string lbl);
        chk({lbl, ".nwrites"}, wlog.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s.write%0d", lbl, i), (i < wlog.size()) ? wlog[i] : -1, exp_q[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 rst = 1'b0;
        #1;
        chk("reset.alu_ready_after", alu_ready, 1'b1);
        chk("reset.mem_ready_after", mem_ready, 1'b1);

        // Single uncontended write.
        wlog.delete();
        step("single_n", 1, 5'd5, 64'hDEAD, 0, 5'd0, 64'd0);
        chk("single.pend_n", pending[5], 1'b1);
        chk("single.we_n", regWrite, 1'b0);
        step("single_n1", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        chk("single.we_n1", regWrite, 1'b1);
        chk("single.wr_n1", writeRegister, 5'd5);
        chk("single.wd_n1", writeData, 64'hDEAD);
        chk("single.pend_n1", pending[5], 1'b1);
        step("single_n2", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        chk("single.we_n2", regWrite, 1'b0);
        chk("single.pend_n2", pending, 32'd0);

        // Contention from a fresh pointer: order 1,3,2,4.
        mid_reset("cont_rst");
        wlog.delete();
        step("cont", 1, 5'd1, 64'h11, 1, 5'd3, 64'h33);
        step("cont", 1, 5'd2, 64'h22, 1, 5'd4, 64'h44);
        idle("cont_drain", 5);
        exp_q = '{1, 3, 2, 4};
        check_log("cont");

        // Backpressure: lone MEM stream never fills, then both streams saturate.
        for (int i = 0; i < 4; i++) begin
            step("bp_mem", 0, 5'd0, 64'd0, 1, 5'(11 + i), 64'(100 + i));
            chk($sformatf("bp.mem_ready%0d", i), mem_ready, 1'b1);
        end
        idle("bp_gap", 2);
        wlog.delete();
        n_acc = 0;
        for (int i = 0; i < 6; i++)
            step("bp_fill", 1, 5'(16 + i), 64'(200 + i), 1, 5'(24 + i), 64'(300 + i));
        chk("bp.mem_full_seen", mem_ready, 1'b0);
        idle("bp_drain", 6);
        chk("bp.no_loss", wlog.size(), n_acc);

        // x0 is accepted and discarded.
        wlog.delete();
        step("x0", 1, 5'd0, 64'hFFFF, 0, 5'd0, 64'd0);
        chk("x0.alu_ready", alu_ready, 1'b1);
        chk("x0.pending", pending, 32'd0);
        idle("x0_after", 2);
        chk("x0.nwrites", wlog.size(), 0);

        // Reset with traffic queued, then ALU wins the first tie.
        step("rmid_fill", 1, 5'd1, 64'hA1, 1, 5'd2, 64'hB2);
        step("rmid_fill", 1, 5'd3, 64'hA3, 1, 5'd5, 64'hB5);
        mid_reset("rmid");
        chk("rmid.regWrite", regWrite, 1'b0);
        chk("rmid.pending", pending, 32'd0);
        wlog.delete();
        step("rmid_tie", 1, 5'd7, 64'hC7, 1, 5'd8, 64'hD8);
        idle("rmid_drain", 3);
        exp_q = '{7, 8};
        check_log("rmid");

        // Pointer wrap through the ALU FIFO.
        wlog.delete();
        for (int i = 0; i < 5; i++) step("wrap", 1, 5'(6 + i), 64'(500 + i), 0, 5'd0, 64'd0);
        idle("wrap_drain", 3);
        exp_q = '{6, 7, 8, 9, 10};
        check_log("wrap");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step("rand",
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
        idle("rand_drain", 5);
        chk("rand.idle_pending", pending, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x64 register file between two writeback requesters: ALU (req 0) and load/memory (req 1).
- Each requester has a small FIFO with a valid/ready handshake. Arbitration between FIFO heads is round-robin.
- The block drives the register file's regWrite/writeRegister/writeData from a registered output stage.
- It exports a per-register pending mask that the hazard logic uses to stall reads of registers with in-flight writes.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, >=2).
- XLEN, 64, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU FIFO can accept.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load FIFO can accept.
- mem_rd  in  AW  load destination register.
- mem_data  in  XLEN  load data.
- regWrite  out  1  register-file write enable.
- writeRegister  out  AW  register-file write address.
- writeData  out  XLEN  register-file write data.
- pending  out  32  bit r = 1 while a write to r is queued or in the output stage.

Behaviour:
- Reset (async, immediate):
  - Both FIFOs are emptied.
  - regWrite=0, writeRegister=0, writeData=0.
  - Round-robin pointer selects ALU first.
  - pending=0.
  - alu_ready=mem_ready=1 once rst deasserts.
- Handshake:
  - A transfer occurs on a posedge where valid && ready.
  - ready = !full of that FIFO. It is combinational on FIFO state only, never on valid.
  - No enqueue into a full FIFO, even if that FIFO dequeues the same cycle (no bypass).
- x0: a transfer with rd=0 completes the handshake but is discarded. It is not enqueued, does not set pending, and never produces a write.
- Arbitration each cycle over non-empty FIFO heads:
  - Only one non-empty: it is granted.
  - Both non-empty: the requester not granted last time wins; the pointer then flips.
  - Neither non-empty: no grant; the pointer is held.
- Output stage:
  - On a grant, the head entry dequeues at the posedge.
  - The same posedge loads regWrite=1, writeRegister=rd, writeData=data.
  - With no grant, regWrite=0 at that posedge; writeRegister and writeData hold their last values.
- Latency:
  - An entry accepted at posedge N with the FIFO otherwise empty and no contention is granted at posedge N+1.
  - regWrite is high from N+1 to N+2, and the register file captures it at posedge N+2.
  - Sustained throughput is one write per cycle in total.
- Ordering:
  - FIFO order is preserved within a requester.
  - There is no ordering between requesters. Two requesters targeting the same rd are the issuer's responsibility, using pending.
- pending:
  - Combinational OR of the one-hot decode of every valid FIFO entry's rd, plus writeRegister when regWrite=1.
  - It clears the cycle after the output stage retires the last write to that register.
- Simultaneous enqueue and dequeue on a non-full FIFO: both happen and the count is unchanged.
- Wrap-around: FIFO pointers are AW-independent, log2(DEPTH) bits, and wrap modulo DEPTH. An extra bit or a count distinguishes full from empty.
- Reset mid-operation: queued writes are lost and no partial write is issued. regWrite drops asynchronously with rst.

Decomposition:
- Package regfile_pkg: XLEN=64, AW=5, NUM_REGS=32, REQ_ALU=0, REQ_MEM=1, and a writeback-entry struct {rd[AW], data[XLEN]}.
- Sub-module wb_fifo, instantiated twice:
  - Parameterised DEPTH.
  - Ports: push/pop/full/empty/head.
  - Also exports an occupied-rd mask for the pending computation.

Test Plan:
- Single write: after reset, alu_valid=1, alu_rd=5, alu_data=0xDEAD for one cycle (accepted at posedge N) -> regWrite=1, writeRegister=5, writeData=0xDEAD during N+1..N+2; pending[5]=1 from N to N+2, then 0.
- Contention: both FIFOs hold 2 entries, ALU rd=1,2 and MEM rd=3,4 -> writes issue in order 1,3,2,4, regWrite is high 4 consecutive cycles, then 0.
- Backpressure: hold mem_valid=1 for 4 cycles while ALU continuously wins no grant (ALU idle) -> mem_ready never deasserts. Then stall the output by filling both FIFOs, and check mem_ready=0 exactly when the MEM FIFO count=2 and that no entry is lost or duplicated.
- x0 discard: alu_valid=1, alu_rd=0, data=0xFFFF -> alu_ready stays 1, pending stays 0, regWrite never asserts.
- Reset mid-operation: 3 entries queued, assert rst between posedges -> regWrite, pending and FIFO counts go to 0 immediately. After release, the first accepted request is granted to ALU on a tie.
- Full/wrap: enqueue 5 entries (rd=6..10) through the ALU FIFO with continuous draining -> writes appear in order 6..10, confirming pointer wrap.
